// File: rtl/add_rr_sched_pkg.sv
// rtl/add_rr_sched_pkg.sv - shared types, default sizes and ID width helper for the adder scheduler
package add_rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_W       = 16;
    localparam int DEF_TIMEOUT = 8;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_rr_sched_arb.sv
// rtl/add_rr_sched_arb.sv - combinational round-robin arbiter (rr_arbiter): first request at or above ptr, wrapping
module rr_arbiter
    import add_rr_sched_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]             req,
    input  logic [id_width(N)-1:0]   ptr,
    output logic [N-1:0]             grant,
    output logic [id_width(N)-1:0]   idx,
    output logic                     any
);

    localparam int IW = id_width(N);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/add_rr_sched.sv
// rtl/add_rr_sched.sv - round-robin sharing of one single-cycle adder among N requesters
// Optional wait timeout with error response: define ADD_RR_SCHED_TIMEOUT_EN.
module add_rr_sched
    import add_rr_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    output logic [N-1:0]             req_ready,
    input  logic [N*W-1:0]           req_a,
    input  logic [N*W-1:0]           req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [id_width(N)-1:0]   rsp_id,
    output logic [W-1:0]             rsp_data,
    output logic                     rsp_err,
    output logic                     add_start,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    input  logic [W-1:0]             add_y,
    input  logic                     add_valid,
    output logic                     busy
);

    localparam int IW = id_width(N);

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("add_rr_sched: unsupported N or TIMEOUT");
    end

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_any;
    logic            timeout_hit;

    rr_arbiter #(.N(N)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        add_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst ? '0 : grant;
                if (grant_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                add_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (add_valid || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay registered after ISSUE so the adder may sample them late.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                add_a  <= req_a[grant_idx*W +: W];
                add_b  <= req_b[grant_idx*W +: W];
                rsp_id <= grant_idx;
            end
            if (state == WAIT) begin
                if (add_valid)        rsp_data <= add_y;
                else if (timeout_hit) rsp_data <= '0;
            end
            if (state == RESP && rsp_ready)
                ptr <= (rsp_id == IW'(N-1)) ? '0 : rsp_id + 1'b1;
        end
    end

`ifdef ADD_RR_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign timeout_hit = (state == WAIT) && !add_valid && (wait_cnt == CW'(TIMEOUT - 1));
    assign rsp_err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (state == WAIT) begin
                if (add_valid)        err_q <= 1'b0;
                else if (timeout_hit) err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_add_rr_sched.sv
// tb/tb_add_rr_sched.sv - scoreboard bench for add_rr_sched with a behavioural adder and round-robin model
module tb_add_rr_sched;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 8;
    localparam int IW      = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             add_start;
    logic [W-1:0]     add_a, add_b;
    logic [W-1:0]     add_y = '0;
    logic             add_valid = 1'b0;
    logic             busy;

    add_rr_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_y(add_y), .add_valid(add_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       err;
        int         t_acc;
        int         lat;
    } exp_t;

    exp_t         exp_q[$];
    int           dut_glog[$];
    int           vectors = 0, errors = 0, cyc = 0;
    int           acc_cnt = 0, rsp_cnt = 0, m_ptr = 0, t_acc = 0;
    int           lat = 1;
    logic         suppress = 1'b0;
    int           mode = 0;
    logic         pend[N];
    logic [W-1:0] opa[N], opb[N];
    logic [W-1:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Adder with programmable latency; suppress models an adder that never answers.
    int           ad_cnt = 0;
    logic [W-1:0] ad_sum = '0;
    always @(posedge clk) begin
        add_valid <= 1'b0;
        if (ad_cnt != 0) begin
            ad_cnt <= ad_cnt - 1;
            if (ad_cnt == 1 && !suppress) begin
                add_valid <= 1'b1;
                add_y     <= ad_sum;
            end
        end
        if (add_start) begin
            ad_sum <= add_a + add_b;
            if (lat <= 1) begin
                if (!suppress) add_valid <= 1'b1;
                add_y <= add_a + add_b;
            end else begin
                ad_cnt <= lat - 1;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = opa[i];
            req_b[i*W +: W]    = opb[i];
        end
    endtask

    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (acc_cnt == rsp_cnt) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("add_start", 64'(add_start), 64'(acc_cnt != rsp_cnt && cyc == t_acc + 1));
        chk("busy", 64'(busy), 64'(acc_cnt != rsp_cnt));
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_glog.push_back(i);
        if (g >= 0) begin
            e.id    = g;
            e.err   = suppress;
            e.data  = suppress ? '0 : W'(opa[g] + opb[g]);
            e.t_acc = cyc;
            e.lat   = suppress ? 2 + TIMEOUT : 2 + lat;
            exp_q.push_back(e);
            acc_cnt <= acc_cnt + 1;
            t_acc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (g >= 0) begin
            if (mode == 0) pend[g] = 1'b0;
            else if (mode == 2) begin
                pend[g] = 1'($urandom_range(0, 1));
                opa[g]  = W'($urandom);
                opb[g]  = W'($urandom);
            end
        end
        if (mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (i != g && $urandom_range(0, 7) == 0) begin
                    pend[i] = ~pend[i];
                    opa[i]  = W'($urandom);
                    opb[i]  = W'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        acc_cnt <= 0;
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_add_start", 64'(add_start), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err",   64'(rsp_err),   64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_add_a",     64'(add_a),     64'(0));
        chk("rst_add_b",     64'(add_b),     64'(0));
        chk("rst_rsp_data",  64'(rsp_data),  64'(0));
        chk("rst_rsp_id",    64'(rsp_id),    64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    logic          hold = 1'b0;
    logic [IW-1:0] h_id;
    logic [W-1:0]  h_data;
    logic          h_err;
    always @(negedge clk) begin
        if (rst) begin
            rsp_cnt <= 0;
            m_ptr   <= 0;
            hold    <= 1'b0;
            exp_q.delete();
        end else begin
            if (hold) begin
                chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
                chk("hold_rsp_id",    64'(rsp_id),    64'(h_id));
                chk("hold_rsp_data",  64'(rsp_data),  64'(h_data));
                chk("hold_rsp_err",   64'(rsp_err),   64'(h_err));
            end
            chk("rsp_expected", 64'(rsp_valid && exp_q.size() == 0), 64'(0));
            if (rsp_valid && exp_q.size() > 0) begin
                if (!hold)
                    chk("rsp_latency", 64'(cyc - exp_q[0].t_acc), 64'(exp_q[0].lat));
                if (rsp_ready) begin
                    chk("rsp_id",   64'(rsp_id),   64'(exp_q[0].id));
                    chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                    chk("rsp_err",  64'(rsp_err),  64'(exp_q[0].err));
                    m_ptr     <= (exp_q[0].id + 1) % N;
                    rsp_cnt   <= rsp_cnt + 1;
                    last_data <= rsp_data;
                    exp_q.delete(0);
                end
            end
            hold   <= rsp_valid && !rsp_ready;
            h_id   <= rsp_id;
            h_data <= rsp_data;
            h_err  <= rsp_err;
        end
    end

    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            opa[i]  = '0;
            opb[i]  = '0;
        end
        do_reset();

        // single requester
        mode = 0; rsp_ready = 1'b1;
        pend[0] = 1'b1; opa[0] = 16'd100; opb[0] = 16'd23;
        drive();
        repeat (6) cycle();
        chk("single_sum", 64'(last_data), 64'(123));

        // all requesters held valid: fairness order from pointer 0
        do_reset();
        dut_glog.delete();
        mode = 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; opa[i] = W'(i); opb[i] = W'(10 * i);
        end
        drive();
        repeat (21) cycle();
        if (dut_glog.size() < 5) chk("grant_count", 64'(dut_glog.size()), 64'(5));
        else begin
            chk("grant_order0", 64'(dut_glog[0]), 64'(0));
            chk("grant_order1", 64'(dut_glog[1]), 64'(1));
            chk("grant_order2", 64'(dut_glog[2]), 64'(2));
            chk("grant_order3", 64'(dut_glog[3]), 64'(3));
            chk("grant_order4", 64'(dut_glog[4]), 64'(0));
        end

        // back-pressure in RESP
        rsp_ready = 1'b0;
        repeat (12) cycle();
        rsp_ready = 1'b1;
        k = dut_glog.size();
        repeat (8) cycle();
        if (dut_glog.size() <= k) chk("grant_after_stall", 64'(dut_glog.size()), 64'(k + 1));
        else chk("grant_after_stall", 64'(dut_glog[k]), 64'((dut_glog[k-1] + 1) % N));

        // wrap-around
        mode = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        repeat (6) cycle();
        pend[2] = 1'b1; opa[2] = 16'hFFFF; opb[2] = 16'h0002;
        drive();
        repeat (6) cycle();
        chk("wrap_sum", 64'(last_data), 64'(16'h0001));

        // reset while waiting on a slow adder; its late valid must be ignored
        lat = 3;
        pend[1] = 1'b1; opa[1] = 16'd5; opb[1] = 16'd6;
        drive();
        repeat (2) cycle();
        do_reset();
        repeat (6) cycle();
        lat = 1;
        dut_glog.delete();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; opa[i] = W'($urandom); opb[i] = W'($urandom);
        end
        drive();
        cycle();
        if (dut_glog.size() == 0) chk("grant_after_reset", 64'(0), 64'(1));
        else chk("grant_after_reset", 64'(dut_glog[0]), 64'(0));

        // randomized traffic with random back-pressure and dropped requests
        mode = 2;
        repeat (400) cycle();
        mode = 0; rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        repeat (8) cycle();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

`ifdef ADD_RR_SCHED_TIMEOUT_EN
        suppress = 1'b1;
        pend[0] = 1'b1; opa[0] = 16'd7; opb[0] = 16'd8;
        drive();
        repeat (14) cycle();
        suppress = 1'b0;
        pend[3] = 1'b1; opa[3] = 16'd30; opb[3] = 16'd12;
        drive();
        repeat (6) cycle();
        chk("after_timeout_sum", 64'(last_data), 64'(42));
        chk("timeout_drained", 64'(exp_q.size()), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/add_rr_sched.md
Name: add_rr_sched

Overview:
- Round-robin scheduler that shares one single-cycle-latency adder datapath (start/a/b in, y/valid out one cycle later) between N requesters.
- Accepts one operand pair at a time over per-requester valid/ready handshakes, sequences the adder's start pulse, captures the sum and returns it with the requester ID.
- Sits between the client blocks and the shared adder instance. Only one transaction is in flight at any time.

Parameters:
- N, 4, number of requesters (2..8).
- W, 16, operand/result width; must equal the adder's W.
- TIMEOUT, 8, maximum cycles to wait for adder valid (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N  requester i has an operand pair.
- req_ready  out  N  one-hot accept; at most one bit high.
- req_a  in  N*W  operand a; slice i is bits [i*W +: W].
- req_b  in  N*W  operand b; slice i is bits [i*W +: W].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(N)  index of the requester that owns the result.
- rsp_data  out  W  sum, modulo 2^W.
- rsp_err  out  1  result invalid (timeout); tied 0 without the optional feature.
- add_start  out  1  single-cycle start pulse to the adder.
- add_a  out  W  registered operand a, held stable from ISSUE until the next accept.
- add_b  out  W  registered operand b, held stable from ISSUE until the next accept.
- add_y  in  W  adder result.
- add_valid  in  1  adder result valid.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset, sampled on posedge clk while rst=1:
  - State is IDLE and the round-robin pointer is 0.
  - req_ready, add_start, rsp_valid, rsp_err and busy are 0.
  - add_a, add_b, rsp_data and rsp_id are 0.
- A reset asserted mid-transaction abandons the transaction. No response is produced, and a late add_valid after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from pointer upward and wrapping modulo N.
  - req_ready[grant]=1 combinationally in the same cycle; all other bits are 0.
  - If no req_valid bit is set, req_ready is 0 and the FSM stays in IDLE.
  - On handshake: latch req_a/req_b of grant into add_a/add_b, latch grant into rsp_id, go to ISSUE.
- ISSUE: add_start=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - On add_valid=1, latch add_y into rsp_data and go to RESP.
  - Nominal latency is 1 cycle, so WAIT normally lasts 1 cycle.
  - add_valid seen in any state other than WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On that handshake: pointer becomes (rsp_id+1) mod N, FSM returns to IDLE.
  - Consecutive grants therefore never go to the same requester while others are waiting.
- Best case is one accept every 4 cycles with rsp_ready tied 1: accept in IDLE at cycle t, start at t+1, result captured at t+2, rsp_valid at t+3.
- A requester that drops req_valid before being granted is simply skipped.
- busy=1 in ISSUE, WAIT and RESP.
- The sum wraps modulo 2^W; there is no saturation and no carry-out.

Optional Feature:
- Macro: ADD_RR_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A counter is cleared on entry to WAIT and incremented each cycle in WAIT.
  - If it reaches TIMEOUT without add_valid, go to RESP with rsp_err=1 and rsp_data=0.
  - rsp_err=0 for normal completions.
- Without the macro: no counter is built, rsp_err is constant 0, and WAIT waits indefinitely.

Decomposition:
- Package add_rr_sched_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - the default constants for W, N and TIMEOUT;
  - the ID width function $clog2(N).
- One sub-module, rr_arbiter. It is purely combinational: request vector + pointer in, one-hot grant and encoded index out.
- The FSM, operand/result registers and timeout counter live in the top module.

Test Plan:
- Single requester: req_valid=4'b0001, a=100, b=23, rsp_ready=1 → add_start 1 cycle after accept; rsp_valid 3 cycles after accept with rsp_id=0, rsp_data=123; busy low afterwards.
- All four requesters held valid with a=i, b=10*i → grant order 0,1,2,3,0; each rsp_data equals 11*i; req_ready never shows more than one bit high.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_id and rsp_data stable; no new req_ready during the stall; next grant after release is rsp_id+1.
- Wrap-around: a=16'hFFFF, b=16'h0002 → rsp_data=16'h0001.
- Reset mid-WAIT: assert rst for 1 cycle while in WAIT → all outputs 0, pointer 0, no rsp_valid; the adder's late add_valid is ignored.
- With ADD_RR_SCHED_TIMEOUT_EN and the adder valid suppressed: after TIMEOUT=8 cycles in WAIT, rsp_valid=1, rsp_err=1, rsp_data=0; the next transaction completes normally with rsp_err=0.
